// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and encodings for the multicycle ARM-subset controller.
//   state_t      controller FSM states
//   IMM_*        imm_src encodings for the immediate extender
//   ALU_*        alu_control encodings
//   SRCB_*       alu_src_b encodings
//   RES_*        result_src encodings
//   CMD_*        data-processing cmd field values (Instr[24:21])
//   alu_decode() maps a DP cmd to an ALU operation
// Optional feature macro: CTRL_BL_EN (adds the StLink state for branch-with-link).
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecuteR = 4'd2,
        StExecuteI = 4'd3,
        StAluWb    = 4'd4,
        StMemAdr   = 4'd5,
        StMemRead  = 4'd6,
        StMemWb    = 4'd7,
        StMemWrite = 4'd8,
        StBranch   = 4'd9,
        StLink     = 4'd10
    } state_t;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_BR = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Unsupported commands fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] op;
        case (cmd)
            CMD_ADD: op = ALU_ADD;
            CMD_SUB: op = ALU_SUB;
            CMD_CMP: op = ALU_SUB;
            CMD_AND: op = ALU_AND;
            CMD_ORR: op = ALU_ORR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates an ARM condition field against NZCV flags.
//   cond     in  4  Instr[31:28]
//   flags    in  4  {N, Z, C, V}
//   cond_ex  out 1  instruction should execute
// Encoding 1111 is treated as never-execute.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle ARM-subset CPU.
// Sequences fetch/decode/execute/memory/writeback over a shared PC/ALU/memory datapath,
// holds the NZCV register and gates execution on the condition field.
// Parameters:
//   STALL_LIMIT  consecutive mem_ready=0 cycles in a memory state before timeout (0 = never)
//   FLAGS_RST    reset value of NZCV
// Ports:
//   clk, reset (sync, active-high), mem_ready
//   instr_cond/op/funct/rd  decoded instruction fields from the IR
//   alu_flags               NZCV from the ALU this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, alu_src_b,
//   result_src, imm_src, alu_control  datapath controls
//   flags                   registered NZCV
//   err_timeout             one-cycle pulse on memory stall timeout
//   reg_lr                  (CTRL_BL_EN only) force destination register to R14
// Macro CTRL_BL_EN: enables BL (branch then link writeback to R14).
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 16,
    parameter logic [3:0]  FLAGS_RST   = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_ready,
    input  logic [3:0] instr_cond,
    input  logic [1:0] instr_op,
    input  logic [5:0] instr_funct,
    input  logic [3:0] instr_rd,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] alu_control,
    output logic [3:0] flags,
`ifdef CTRL_BL_EN
    output logic       reg_lr,
`endif
    output logic       err_timeout
);

    // Counter only needs to reach STALL_LIMIT-1; the limit-th stall cycle is the timeout.
    localparam int unsigned CNT_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] stall_cnt;
    logic             cond_ex;
    logic             is_mem_state;
    logic             timeout;
    logic             is_cmp;
    logic             s_bit;
    logic             rd_pc;

    assign is_cmp = (instr_funct[4:1] == CMD_CMP);
    assign s_bit  = instr_funct[0];
    assign rd_pc  = (instr_rd == 4'd15);

    cond_check u_cond_check (
        .cond    (instr_cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign is_mem_state = (state == StFetch) || (state == StMemRead) || (state == StMemWrite);
    assign timeout      = (STALL_LIMIT != 0) && is_mem_state && !mem_ready &&
                          (stall_cnt == CNT_W'(STALL_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StFetch;
            flags     <= FLAGS_RST;
            stall_cnt <= '0;
        end else begin
            if (is_mem_state && !mem_ready && !timeout) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= '0;
            end

            if ((state == StExecuteR || state == StExecuteI) && (s_bit || is_cmp)) begin
                flags <= alu_flags;
            end

            if (timeout) begin
                state <= StFetch;
            end else begin
                case (state)
                    StFetch: if (mem_ready) state <= StDecode;
                    StDecode: begin
                        if (!cond_ex) begin
                            state <= StFetch;
                        end else begin
                            case (instr_op)
                                2'b00:   state <= instr_funct[5] ? StExecuteI : StExecuteR;
                                2'b01:   state <= StMemAdr;
                                2'b10:   state <= StBranch;
                                default: state <= StFetch;
                            endcase
                        end
                    end
                    StExecuteR: state <= StAluWb;
                    StExecuteI: state <= StAluWb;
                    StAluWb:    state <= StFetch;
                    StMemAdr:   state <= instr_funct[0] ? StMemRead : StMemWrite;
                    StMemRead:  if (mem_ready) state <= StMemWb;
                    StMemWb:    state <= StFetch;
                    StMemWrite: if (mem_ready) state <= StFetch;
`ifdef CTRL_BL_EN
                    StBranch:   state <= instr_funct[4] ? StLink : StFetch;
                    StLink:     state <= StFetch;
`else
                    StBranch:   state <= StFetch;
`endif
                    default:    state <= StFetch;
                endcase
            end
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        result_src  = RES_ALUOUT;
        imm_src     = IMM_8;
        alu_control = ALU_ADD;
`ifdef CTRL_BL_EN
        reg_lr      = 1'b0;
`endif
        case (state)
            StFetch: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            StDecode: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                imm_src    = instr_op;
            end
            StExecuteR: begin
                alu_src_b   = SRCB_REG;
                alu_control = alu_decode(instr_funct[4:1]);
            end
            StExecuteI: begin
                alu_src_b   = SRCB_IMM;
                alu_control = alu_decode(instr_funct[4:1]);
            end
            StAluWb: begin
                result_src = RES_ALUOUT;
                reg_write  = !is_cmp && !rd_pc;
                pc_write   = !is_cmp && rd_pc;
            end
            StMemAdr: begin
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_12;
            end
            StMemRead: adr_src = 1'b1;
            StMemWb: begin
                result_src = RES_DATA;
                reg_write  = !rd_pc;
                pc_write   = rd_pc;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            StBranch: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_BR;
                result_src = RES_ALURES;
                pc_write   = 1'b1;
            end
`ifdef CTRL_BL_EN
            StLink: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                reg_write  = 1'b1;
                reg_lr     = 1'b1;
            end
`endif
            default: ;
        endcase

        // A timed-out access must not complete a write.
        if (timeout) begin
            mem_write = 1'b0;
        end
        if (reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign err_timeout = timeout && !reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller.
// Inputs change 1 ns after the falling edge; outputs are sampled before the next rising edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [3:0] instr_cond;
    logic [1:0] instr_op;
    logic [5:0] instr_funct;
    logic [3:0] instr_rd;
    logic [3:0] alu_flags;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, alu_control;
    logic [3:0] flags;
    logic       err_timeout;
`ifdef CTRL_BL_EN
    logic       reg_lr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .STALL_LIMIT (16),
        .FLAGS_RST   (4'b0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_ready   (mem_ready),
        .instr_cond  (instr_cond),
        .instr_op    (instr_op),
        .instr_funct (instr_funct),
        .instr_rd    (instr_rd),
        .alu_flags   (alu_flags),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .flags       (flags),
`ifdef CTRL_BL_EN
        .reg_lr      (reg_lr),
`endif
        .err_timeout (err_timeout)
    );

    // Advance one cycle; returns 1 ns after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r);
        instr_cond  = c;
        instr_op    = o;
        instr_funct = f;
        instr_rd    = r;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; alu_flags = 4'b0000;
        set_instr(4'b1110, 2'b00, 6'b000000, 4'd0);
        tick(); tick();
        checks++; if ({pc_write, ir_write, reg_write, mem_write, err_timeout} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b exp 00000",
                {pc_write, ir_write, reg_write, mem_write, err_timeout}); end
        checks++; if (flags !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b exp 0000", flags); end
        reset = 1'b0; #1;
        checks++; if ({ir_write, pc_write, adr_src, alu_src_a, alu_src_b, result_src}
                      !== 8'b11_0_1_10_10) begin
            errors++; $display("FAIL reset_fetch: got %b exp 11011010",
                {ir_write, pc_write, adr_src, alu_src_a, alu_src_b, result_src}); end
    endtask

    // ADD R1,R2,#5: FETCH, DECODE, EXECUTEI, ALUWB.
    task automatic test_add_imm();
        int wr = 0;
        set_instr(4'b1110, 2'b00, 6'b101000, 4'd1);
        mem_ready = 1'b1; alu_flags = 4'b1111; #1;
        wr += int'(reg_write);
        tick();  // DECODE
        wr += int'(reg_write);
        checks++; if ({alu_src_a, alu_src_b, imm_src, pc_write} !== 6'b1_10_00_0) begin
            errors++; $display("FAIL add_decode: got %b exp 110000",
                {alu_src_a, alu_src_b, imm_src, pc_write}); end
        tick();  // EXECUTEI
        wr += int'(reg_write);
        checks++; if ({alu_src_a, alu_src_b, alu_control} !== 5'b0_01_00) begin
            errors++; $display("FAIL add_exec: got %b exp 00100",
                {alu_src_a, alu_src_b, alu_control}); end
        tick();  // ALUWB
        checks++; if ({reg_write, pc_write, result_src} !== 4'b1_0_00) begin
            errors++; $display("FAIL add_aluwb: got %b exp 1000",
                {reg_write, pc_write, result_src}); end
        checks++; if (wr !== 0) begin
            errors++; $display("FAIL add_early_write: got %0d exp 0", wr); end
        tick();  // FETCH
        checks++; if (ir_write !== 1'b1) begin
            errors++; $display("FAIL add_back_fetch: got %b exp 1", ir_write); end
        checks++; if (flags !== 4'b0000) begin
            errors++; $display("FAIL add_flags: got %b exp 0000", flags); end
    endtask

    // SUBS R3,R3,R4 sets Z, then BEQ is taken.
    task automatic test_subs_beq();
        set_instr(4'b1110, 2'b00, 6'b000101, 4'd3);
        mem_ready = 1'b1;
        tick();  // DECODE
        tick();  // EXECUTER
        alu_flags = 4'b0100; #1;
        checks++; if ({alu_src_a, alu_src_b, alu_control} !== 5'b0_00_01) begin
            errors++; $display("FAIL subs_exec: got %b exp 00001",
                {alu_src_a, alu_src_b, alu_control}); end
        tick();  // ALUWB
        alu_flags = 4'b0000;
        checks++; if (flags !== 4'b0100) begin
            errors++; $display("FAIL subs_flags: got %b exp 0100", flags); end
        tick();  // FETCH
        set_instr(4'b0000, 2'b10, 6'b000000, 4'd0);
        tick();  // DECODE
        checks++; if (imm_src !== 2'b10) begin
            errors++; $display("FAIL beq_decode_imm: got %b exp 10", imm_src); end
        tick();  // BRANCH
        checks++; if ({pc_write, imm_src, alu_src_a, alu_src_b, result_src, reg_write}
                      !== 9'b1_10_0_01_10_0) begin
            errors++; $display("FAIL beq_branch: got %b exp 110001100",
                {pc_write, imm_src, alu_src_a, alu_src_b, result_src, reg_write}); end
        tick();  // FETCH
        checks++; if (ir_write !== 1'b1) begin
            errors++; $display("FAIL beq_back_fetch: got %b exp 1", ir_write); end
    endtask

    // Z=1: BNE and cond 1111 both drop straight back to FETCH.
    task automatic test_cond_fail();
        logic [3:0] conds [2];
        conds[0] = 4'b0001;
        conds[1] = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            set_instr(conds[k], (k == 0) ? 2'b10 : 2'b00, 6'b101000, 4'd15);
            tick();  // DECODE
            checks++; if ({pc_write, reg_write, mem_write, ir_write} !== 4'b0) begin
                errors++; $display("FAIL cond_fail_decode_%0d: got %b exp 0000", k,
                    {pc_write, reg_write, mem_write, ir_write}); end
            tick();  // FETCH expected
            checks++; if ({ir_write, adr_src, alu_src_a, alu_src_b} !== 5'b1_0_1_10) begin
                errors++; $display("FAIL cond_fail_fetch_%0d: got %b exp 10110", k,
                    {ir_write, adr_src, alu_src_a, alu_src_b}); end
        end
    endtask

    // LDR with three wait states in MEMREAD.
    task automatic test_ldr_wait();
        int wr = 0;
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd5);
        tick();  // DECODE
        wr += int'(reg_write);
        tick();  // MEMADR
        wr += int'(reg_write);
        checks++; if ({imm_src, alu_src_b, alu_src_a} !== 5'b01_01_0) begin
            errors++; $display("FAIL ldr_memadr: got %b exp 01010",
                {imm_src, alu_src_b, alu_src_a}); end
        tick();  // MEMREAD
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            wr += int'(reg_write);
            checks++; if ({adr_src, mem_write} !== 2'b10) begin
                errors++; $display("FAIL ldr_wait_%0d: got %b exp 10", i,
                    {adr_src, mem_write}); end
            tick();
        end
        mem_ready = 1'b1; #1;
        wr += int'(reg_write);
        checks++; if (adr_src !== 1'b1) begin
            errors++; $display("FAIL ldr_memread_done: got %b exp 1", adr_src); end
        tick();  // MEMWB
        wr += int'(reg_write);
        checks++; if ({result_src, pc_write} !== 3'b01_0) begin
            errors++; $display("FAIL ldr_memwb: got %b exp 010", {result_src, pc_write}); end
        tick();  // FETCH
        checks++; if (wr !== 1 || ir_write !== 1'b1) begin
            errors++; $display("FAIL ldr_writes: got %0d/%b exp 1/1", wr, ir_write); end
    endtask

    // STR with mem_ready stuck low times out on the 16th stall cycle.
    task automatic test_str_timeout();
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd7);
        tick();  // DECODE
        tick();  // MEMADR
        tick();  // MEMWRITE
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (err_timeout !== (i == 15)) begin
                errors++; $display("FAIL str_timeout_%0d: got %b exp %b", i, err_timeout,
                    (i == 15)); end
            if (i < 15) begin
                checks++; if (mem_write !== 1'b1) begin
                    errors++; $display("FAIL str_memwrite_%0d: got %b exp 1", i, mem_write); end
            end
            tick();
        end
        checks++; if ({mem_write, err_timeout, adr_src, alu_src_a, alu_src_b}
                      !== 6'b0_0_0_1_10) begin
            errors++; $display("FAIL str_after_timeout: got %b exp 000110",
                {mem_write, err_timeout, adr_src, alu_src_a, alu_src_b}); end
        mem_ready = 1'b1; #1;
        checks++; if (ir_write !== 1'b1) begin
            errors++; $display("FAIL str_refetch: got %b exp 1", ir_write); end
    endtask

    // ORR to R15 writes PC; CMP updates flags without a register write.
    task automatic test_alu_decode();
        set_instr(4'b1110, 2'b00, 6'b011000, 4'd15);
        tick();  // DECODE
        tick();  // EXECUTER
        checks++; if (alu_control !== 2'b11) begin
            errors++; $display("FAIL orr_alu: got %b exp 11", alu_control); end
        tick();  // ALUWB
        checks++; if ({pc_write, reg_write} !== 2'b10) begin
            errors++; $display("FAIL orr_pc_wb: got %b exp 10", {pc_write, reg_write}); end
        tick();  // FETCH
        set_instr(4'b1110, 2'b00, 6'b110101, 4'd0);
        tick();  // DECODE
        tick();  // EXECUTEI
        alu_flags = 4'b0011; #1;
        checks++; if ({alu_control, alu_src_b} !== 4'b01_01) begin
            errors++; $display("FAIL cmp_exec: got %b exp 0101", {alu_control, alu_src_b}); end
        tick();  // ALUWB
        alu_flags = 4'b0000;
        checks++; if ({pc_write, reg_write, flags} !== 6'b00_0011) begin
            errors++; $display("FAIL cmp_aluwb: got %b exp 000011",
                {pc_write, reg_write, flags}); end
        tick();  // FETCH
    endtask

    // Reset while a store is waiting abandons it.
    task automatic test_reset_memwrite();
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd2);
        tick();  // DECODE
        tick();  // MEMADR
        tick();  // MEMWRITE
        mem_ready = 1'b0; #1;
        checks++; if (mem_write !== 1'b1) begin
            errors++; $display("FAIL rst_mw_pre: got %b exp 1", mem_write); end
        reset = 1'b1; #1;
        checks++; if (mem_write !== 1'b0) begin
            errors++; $display("FAIL rst_mw_forced: got %b exp 0", mem_write); end
        tick();
        checks++; if ({mem_write, flags} !== 5'b0_0000) begin
            errors++; $display("FAIL rst_mw_flags: got %b exp 00000", {mem_write, flags}); end
        reset = 1'b0; mem_ready = 1'b1; #1;
        checks++; if ({ir_write, adr_src, mem_write} !== 3'b100) begin
            errors++; $display("FAIL rst_mw_fetch: got %b exp 100",
                {ir_write, adr_src, mem_write}); end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_subs_beq();
        test_cond_fail();
        test_ldr_wait();
        test_str_timeout();
        test_alu_decode();
        test_reset_memwrite();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
